markov_table_merge: RTL

MARKOV_TABLE_MERGE -- requirements
Module: markov_table_merge

---
 rtl/markov_table_merge_pkg.sv | 25 ++
 rtl/markov_entry_combine.sv | 29 ++
 rtl/markov_table_merge.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/markov_table_merge_pkg.sv
// Shared defaults, entry-width helper and FSM encoding for the Markov table merge.
// Latency: n/a (definitions only). Backpressure: n/a.
// Entry layout: {key, count}, count in the low SEQ_CNT_BIT_LEN bits.
package markov_table_merge_pkg;

    localparam int SEQUENCE_LEN_DEF    = 4;
    localparam int NOTE_BIT_LEN_DEF    = 7;
    localparam int DELAY_BIT_LEN_DEF   = 8;
    localparam int SEQ_CNT_BIT_LEN_DEF = 8;

    function automatic int entry_width(input int seq_len, input int note_bits,
                                       input int delay_bits, input int cnt_bits);
        return seq_len * (note_bits + delay_bits) + cnt_bits;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COPY_A    = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_INCREMENT = 3'd3,
        ST_APPEND    = 3'd4,
        ST_FINISH    = 3'd5
    } merge_state_t;

endpackage

// File: rtl/markov_entry_combine.sv
// Key equality and count accumulation for one pair of Markov entries.
// Latency: combinational. Backpressure: none.
// MARKOV_MERGE_SAT_EN: sums saturate at all-ones instead of wrapping.
module markov_entry_combine
    import markov_table_merge_pkg::*;
#(
    parameter int KEY_W = entry_width(SEQUENCE_LEN_DEF, NOTE_BIT_LEN_DEF,
                                      DELAY_BIT_LEN_DEF, SEQ_CNT_BIT_LEN_DEF) - SEQ_CNT_BIT_LEN_DEF,
    parameter int CNT_W = SEQ_CNT_BIT_LEN_DEF
) (
    input  logic [KEY_W-1:0] key_x,
    input  logic [KEY_W-1:0] key_y,
    input  logic [CNT_W-1:0] cnt_x,
    input  logic [CNT_W-1:0] cnt_y,
    output logic             match,
    output logic [CNT_W-1:0] sum
);

    assign match = (key_x == key_y);

`ifdef MARKOV_MERGE_SAT_EN
    logic [CNT_W:0] wide_sum;
    assign wide_sum = {1'b0, cnt_x} + {1'b0, cnt_y};
    assign sum      = wide_sum[CNT_W] ? '1 : wide_sum[CNT_W-1:0];
`else
    assign sum = cnt_x + cnt_y;
`endif

endmodule

// File: rtl/markov_table_merge.sv
// Copies table A into the output, then folds each B entry in: matching key adds counts, new key appends.
// Latency: 2 + count_a cycles, plus per B entry up to out_count+1 search cycles and 1 update cycle.
// No backpressure; inputs held stable while busy. MARKOV_MERGE_SAT_EN selects saturating count sums.
module markov_table_merge
    import markov_table_merge_pkg::*;
#(
    parameter int  SEQUENCE_LEN    = SEQUENCE_LEN_DEF,
    parameter int  NOTE_BIT_LEN    = NOTE_BIT_LEN_DEF,
    parameter int  DELAY_BIT_LEN   = DELAY_BIT_LEN_DEF,
    parameter int  SEQ_CNT_BIT_LEN = SEQ_CNT_BIT_LEN_DEF,
    parameter int  DEPTH_A         = 8,
    parameter int  DEPTH_B         = 8,
    parameter int  OUT_DEPTH       = DEPTH_A + DEPTH_B,
    localparam int EW   = entry_width(SEQUENCE_LEN, NOTE_BIT_LEN, DELAY_BIT_LEN, SEQ_CNT_BIT_LEN),
    localparam int CA_W = $clog2(DEPTH_A + 1),
    localparam int CB_W = $clog2(DEPTH_B + 1),
    localparam int OC_W = $clog2(OUT_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DEPTH_A*EW-1:0]   markov_a,
    input  logic [CA_W-1:0]         count_a,
    input  logic [DEPTH_B*EW-1:0]   markov_b,
    input  logic [CB_W-1:0]         count_b,
    output logic [OUT_DEPTH*EW-1:0] markov,
    output logic [OC_W-1:0]         out_count,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int KW    = EW - SEQ_CNT_BIT_LEN;
    localparam int IDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    merge_state_t    state_q, state_d;
    logic [OC_W-1:0] out_count_q, out_count_d;
    logic [OC_W-1:0] s_idx_q, s_idx_d;
    logic [CA_W-1:0] a_idx_q, a_idx_d;
    logic [CB_W-1:0] b_idx_q, b_idx_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   table_q [OUT_DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [EW-1:0]    wr_dat;

    logic [CA_W-1:0]            num_a;
    logic [CB_W-1:0]            num_b;
    logic [EW-1:0]              a_entry, b_entry, cmp_entry;
    logic                       key_match, b_last;
    logic [SEQ_CNT_BIT_LEN-1:0] cnt_sum;

    assign num_a = (int'(count_a) > DEPTH_A) ? CA_W'(DEPTH_A) : count_a;
    assign num_b = (int'(count_b) > DEPTH_B) ? CB_W'(DEPTH_B) : count_b;

    assign a_entry   = markov_a[int'(a_idx_q)*EW +: EW];
    assign b_entry   = markov_b[int'(b_idx_q)*EW +: EW];
    // s_idx reaches out_count at the end of a search; keep that read in range.
    assign cmp_entry = (s_idx_q < OC_W'(OUT_DEPTH)) ? table_q[IDX_W'(s_idx_q)] : '0;
    assign b_last    = (b_idx_q == num_b - CB_W'(1));

    markov_entry_combine #(
        .KEY_W (KW),
        .CNT_W (SEQ_CNT_BIT_LEN)
    ) u_combine (
        .key_x (cmp_entry[EW-1:SEQ_CNT_BIT_LEN]),
        .key_y (b_entry[EW-1:SEQ_CNT_BIT_LEN]),
        .cnt_x (cmp_entry[SEQ_CNT_BIT_LEN-1:0]),
        .cnt_y (b_entry[SEQ_CNT_BIT_LEN-1:0]),
        .match (key_match),
        .sum   (cnt_sum)
    );

    always_comb begin
        state_d     = state_q;
        out_count_d = out_count_q;
        s_idx_d     = s_idx_q;
        a_idx_d     = a_idx_q;
        b_idx_d     = b_idx_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_idx      = IDX_W'(out_count_q);
        wr_dat      = '0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d     = ST_COPY_A;
                    out_count_d = '0;
                    overflow_d  = 1'b0;
                    s_idx_d     = '0;
                    a_idx_d     = '0;
                    b_idx_d     = '0;
                end
            end
            ST_COPY_A: begin
                if (a_idx_q == num_a) begin
                    state_d = (num_b == '0) ? ST_FINISH : ST_SEARCH;
                    s_idx_d = '0;
                end else begin
                    a_idx_d = a_idx_q + CA_W'(1);
                    if (out_count_q == OC_W'(OUT_DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        wr_dat      = a_entry;
                        out_count_d = out_count_q + OC_W'(1);
                    end
                end
            end
            ST_SEARCH: begin
                if (s_idx_q == out_count_q) begin
                    state_d = ST_APPEND;
                end else if (key_match) begin
                    state_d = ST_INCREMENT;
                end else begin
                    s_idx_d = s_idx_q + OC_W'(1);
                end
            end
            ST_INCREMENT, ST_APPEND: begin
                if (state_q == ST_INCREMENT) begin
                    wr_en  = 1'b1;
                    wr_idx = IDX_W'(s_idx_q);
                    wr_dat = {b_entry[EW-1:SEQ_CNT_BIT_LEN], cnt_sum};
                end else if (out_count_q == OC_W'(OUT_DEPTH)) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en       = 1'b1;
                    wr_dat      = b_entry;
                    out_count_d = out_count_q + OC_W'(1);
                end
                b_idx_d = b_idx_q + CB_W'(1);
                s_idx_d = '0;
                state_d = b_last ? ST_FINISH : ST_SEARCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_count_q <= '0;
            s_idx_q     <= '0;
            a_idx_q     <= '0;
            b_idx_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_count_q <= out_count_d;
            s_idx_q     <= s_idx_d;
            a_idx_q     <= a_idx_d;
            b_idx_q     <= b_idx_d;
            overflow_q  <= overflow_d;
            if (wr_en) begin
                table_q[wr_idx] <= wr_dat;
            end
        end
    end

    // Slots past out_count may hold data from an earlier merge; mask them.
    for (genvar i = 0; i < OUT_DEPTH; i++) begin : g_out
        assign markov[i*EW +: EW] = (OC_W'(i) < out_count_q) ? table_q[i] : '0;
    end

    assign out_count = out_count_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == ST_COPY_A) || (state_q == ST_SEARCH) ||
                       (state_q == ST_INCREMENT) || (state_q == ST_APPEND);
    assign done      = (state_q == ST_FINISH);

endmodule
